// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the receiver/transmitter state encodings.
package uart_pkg;
  localparam int BAUD_W    = 14;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= {2{RESET_VAL}};
    else       ff <= {ff[0], d};
  end

  assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a programmable baud divisor, one-entry
// holding register, sticky framing/overrun flags.
module uart_rx #(
  parameter int BAUD_W    = uart_pkg::BAUD_W,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  input  logic [BAUD_W-1:0]    baudrate_reg,
  input  logic                 rx_read,
  input  logic                 err_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 overrun_error
);
  import uart_pkg::*;

  localparam int BC_W = $clog2(DATA_BITS);

  rx_state_t            state, state_next;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_s;
  logic                 tick, half, sample, load, ferr;

  uart_sync u_sync (.clk(clk), .reset(reset), .d(RxD), .q(rxd_s));

  assign tick = (baud_cnt == baudrate_reg);
  assign half = (baud_cnt == (baudrate_reg >> 1));
  assign busy = (state != RX_IDLE);

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    load       = 1'b0;
    ferr       = 1'b0;
    case (state)
      RX_IDLE:  if (!rxd_s) state_next = RX_START;
      // A start bit that is high again by its midpoint is treated as noise.
      RX_START: if (half) state_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA: if (tick) begin
        sample = 1'b1;
        if (bit_cnt == BC_W'(DATA_BITS-1)) state_next = RX_STOP;
      end
      RX_STOP: if (tick) begin
        if (rxd_s) begin
          load       = 1'b1;
          state_next = RX_IDLE;
        end else begin
          ferr       = 1'b1;
          state_next = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rxd_s) state_next = RX_IDLE;
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RX_IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state || tick || state == RX_IDLE || state == RX_WAIT_HIGH)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BAUD_W'(1);

      if (state != RX_DATA) bit_cnt <= '0;
      else if (sample)      bit_cnt <= bit_cnt + BC_W'(1);

      if (sample) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};

      if (load) rx_data <= shreg;

      if (load)         rx_ready <= 1'b1;
      else if (rx_read) rx_ready <= 1'b0;

      // New errors take priority over a simultaneous clear.
      if (load && rx_ready && !rx_read) overrun_error <= 1'b1;
      else if (err_clear)               overrun_error <= 1'b0;

      if (ferr)           framing_error <= 1'b1;
      else if (err_clear) framing_error <= 1'b0;
    end
  end
endmodule
